cond_unit_it: RTL

Next-generation ARM condition unit for the Execute stage. It holds per-context NZCV flag registers with split NZ/CV write enables, and evaluates the 4-bit condition field against the stored flags. It sequences Thumb-style IT blocks of up to IT_MAX predicated instructions and gates PCS/RegW/MemW on the result. It sits between the decoder and the register file / memory write strobes, and supports NUM_CTX hardware thread contexts.

---
 rtl/cond_pkg.sv | 42 ++++
 rtl/cond_eval.sv | 39 +++
 rtl/cond_unit_it.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared ARM condition encodings, flag bit positions and per-context IT block state.
package cond_pkg;

    localparam int unsigned COND_W   = 4;
    localparam int unsigned FLAG_W   = 4;
    localparam int unsigned IT_LEN_W = 3;
    localparam int unsigned TE_W     = 3;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic [COND_W-1:0]   base;
        logic [TE_W-1:0]     te;
        logic [IT_LEN_W-1:0] len;
        logic [IT_LEN_W-1:0] remaining;
    } it_state_t;

    // Condition of the current IT slot: slot 0 is always "then", te[k] flips slot k+1.
    function automatic logic [COND_W-1:0] it_slot_cond(input it_state_t s);
        logic [IT_LEN_W-1:0] slot;
        logic                inv;
        slot = s.len - s.remaining;
        case (slot)
            3'd1:    inv = s.te[0];
            3'd2:    inv = s.te[1];
            3'd3:    inv = s.te[2];
            default: inv = 1'b0;
        endcase
        return {s.base[COND_W-1:1], s.base[0] ^ inv};
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: condition field + NZCV -> pass.
module cond_eval
    import cond_pkg::*;
(
    input  logic [COND_W-1:0] cond_i,
    input  logic [FLAG_W-1:0] flags_i,
    output logic              pass_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = ~v;
            COND_HI: pass_o = c & ~z;
            COND_LS: pass_o = ~(c & ~z);
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = ~z & (n == v);
            COND_LE: pass_o = ~(~z & (n == v));
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit_it.sv
// Execute-stage condition unit: per-context NZCV flags, IT block sequencing and
// predication of the PC / register / memory write strobes.
module cond_unit_it
    import cond_pkg::*;
#(
    parameter  int unsigned NUM_CTX = 2,
    parameter  int unsigned IT_MAX  = 4,
    localparam int unsigned CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                valid_i,
    input  logic                flush_i,
    input  logic [CTX_W-1:0]    ctx_i,
    input  logic [COND_W-1:0]   cond_i,
    input  logic [FLAG_W-1:0]   alu_flags_i,
    input  logic [1:0]          flag_w_i,
    input  logic                pcs_i,
    input  logic                reg_w_i,
    input  logic                mem_w_i,
    input  logic                no_write_i,
    input  logic                it_start_i,
    input  logic [COND_W-1:0]   it_cond_i,
    input  logic [IT_LEN_W-1:0] it_len_i,
    input  logic [TE_W-1:0]     it_te_i,
    output logic                cond_ex_o,
    output logic                pcs_o,
    output logic                reg_w_o,
    output logic                mem_w_o,
    output logic [FLAG_W-1:0]   flags_o,
    output logic                in_it_o,
    output logic [IT_LEN_W-1:0] it_remaining_o,
    output logic                illegal_o
);

    logic [FLAG_W-1:0] flags_q [NUM_CTX];
    logic [FLAG_W-1:0] flags_d [NUM_CTX];
    it_state_t         it_q    [NUM_CTX];
    it_state_t         it_d    [NUM_CTX];

    logic [FLAG_W-1:0] cur_flags;
    it_state_t         cur_it;
    logic [COND_W-1:0] eff_cond;
    logic [TE_W-1:0]   te_mask;
    logic ctx_ok, in_it, it_uncond, eval_pass, ce;
    logic it_params_ok, it_attempt, it_load, it_illegal;

    // Select the state of the addressed context.
    always_comb begin
        cur_flags = '0;
        cur_it    = '0;
        for (int unsigned c = 0; c < NUM_CTX; c++) begin
            if (CTX_W'(c) == ctx_i) begin
                cur_flags = flags_q[c];
                cur_it    = it_q[c];
            end
        end
    end

    assign ctx_ok    = (32'(ctx_i) < NUM_CTX);
    assign in_it     = (cur_it.remaining != '0);
    assign eff_cond  = in_it ? it_slot_cond(cur_it) : cond_i;
    assign it_uncond = it_start_i & ~in_it;

    cond_eval u_cond_eval (
        .cond_i  (eff_cond),
        .flags_i (cur_flags),
        .pass_o  (eval_pass)
    );

    // te bits that select a slot inside the requested block length.
    always_comb begin
        case (it_len_i)
            3'd2:    te_mask = 3'b001;
            3'd3:    te_mask = 3'b011;
            3'd4:    te_mask = 3'b111;
            default: te_mask = 3'b000;
        endcase
    end

    assign it_params_ok = (it_len_i != '0) && (32'(it_len_i) <= IT_MAX) &&
                          (it_cond_i != COND_NV) &&
                          !((it_cond_i == COND_AL) && ((it_te_i & te_mask) != '0));
    assign it_attempt   = valid_i & it_start_i & ~flush_i & ctx_ok;
    assign it_load      = it_attempt & ~in_it & it_params_ok;
    assign it_illegal   = it_attempt & (in_it | ~it_params_ok);

    assign cond_ex_o = it_uncond | eval_pass;
    assign ce        = cond_ex_o & valid_i & ~flush_i & ctx_ok;

    assign pcs_o          = pcs_i & ce;
    assign mem_w_o        = mem_w_i & ce;
    assign reg_w_o        = reg_w_i & ce & ~no_write_i;
    assign flags_o        = cur_flags;
    assign in_it_o        = in_it;
    assign it_remaining_o = cur_it.remaining;
    assign illegal_o      = it_illegal | (~it_uncond & (eff_cond == COND_NV));

    // Flush clears every context's block; otherwise only ctx_i is updated.
    always_comb begin
        flags_d = flags_q;
        it_d    = it_q;
        for (int unsigned c = 0; c < NUM_CTX; c++) begin
            if (flush_i) begin
                it_d[c].remaining = '0;
            end else if (CTX_W'(c) == ctx_i) begin
                if (ce && flag_w_i[1]) begin
                    flags_d[c][FLAG_N] = alu_flags_i[FLAG_N];
                    flags_d[c][FLAG_Z] = alu_flags_i[FLAG_Z];
                end
                if (ce && flag_w_i[0]) begin
                    flags_d[c][FLAG_C] = alu_flags_i[FLAG_C];
                    flags_d[c][FLAG_V] = alu_flags_i[FLAG_V];
                end
                if (valid_i && in_it) begin
                    it_d[c].remaining = it_q[c].remaining - 3'd1;
                end
                if (it_load) begin
                    it_d[c] = '{base: it_cond_i, te: it_te_i, len: it_len_i,
                                remaining: it_len_i};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned c = 0; c < NUM_CTX; c++) begin
                flags_q[c] <= '0;
                it_q[c]    <= '0;
            end
        end else begin
            flags_q <= flags_d;
            it_q    <= it_d;
        end
    end

endmodule
